max_pool_stream: RTL and testbench

- Streaming 2x2 / stride-2 pooling block for raster-order pixel streams from the STFT feature path; placed between a conv/threshold stage and the next layer.
- Generalises the binary 2x2 OR pool to multi-bit unsigned pixels, parametrised image size, MAX or AVERAGE mode, and explicit output valid / position / end-of-frame signals.
- One pixel accepted per enabled cycle. An internal half-width line buffer holds horizontal pair results from even rows.

---
 rtl/pool_pkg.sv | 17 +
 rtl/pool_line_buf.sv | 25 ++
 rtl/max_pool_stream.sv | 126 ++++++++++++
 tb/tb_max_pool_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the streaming 2x2 pooling block: mode encoding and a max helper.
package pool_pkg;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } poolMode_e;

    // Wide enough for any DW up to 32 plus the pair-sum carry bit.
    localparam int unsigned POOL_MAX_W = 33;

    function automatic logic [POOL_MAX_W-1:0] pool_max(input logic [POOL_MAX_W-1:0] a,
                                                       input logic [POOL_MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: one synchronous write port, one combinational read port, no reset.
module pool_line_buf #(
    parameter  int unsigned DEPTH = 15,
    parameter  int unsigned WIDTH = 9,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             iCLK,
    input  logic             iWE,
    input  logic [AW-1:0]    iWADDR,
    input  logic [WIDTH-1:0] iWDATA,
    input  logic [AW-1:0]    iRADDR,
    output logic [WIDTH-1:0] oRDATA
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem[iWADDR] <= iWDATA;
        end
    end

    assign oRDATA = mem[iRADDR];

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 MAX or AVG pooling over a raster-order pixel stream.
module max_pool_stream
    import pool_pkg::*;
#(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned IMG_W = 30,
    parameter  int unsigned IMG_H = 30,
    localparam int unsigned OW    = IMG_W / 2,
    localparam int unsigned OH    = IMG_H / 2,
    localparam int unsigned OCW   = (OW > 1) ? $clog2(OW) : 1,
    localparam int unsigned ORW   = (OH > 1) ? $clog2(OH) : 1
) (
    input  logic           iCLK,
    input  logic           iRSTn,
    input  logic           iCLR,
    input  logic           iEN,
    input  logic           iMODE,
    input  logic [DW-1:0]  iDATA,
    output logic [DW-1:0]  oDATA,
    output logic           oVALID,
    output logic [OCW-1:0] oCOL,
    output logic [ORW-1:0] oROW,
    output logic           oLAST
);

    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(IMG_H);
    localparam bit          HOdd = (IMG_H % 2) == 1;

    logic [CW-1:0] colCnt;
    logic [RW-1:0] rowCnt;
    logic [DW-1:0] holdQ;
    poolMode_e     modeQ;

    logic           colLast, rowLast, colOdd, rowOdd, frameStart, rowWrOk;
    logic           lbWe;
    logic [OCW-1:0] lbAddr;
    logic [DW:0]    lbRd;
    logic [DW:0]    hVal;
    logic [DW+1:0]  vSum;
    logic [DW-1:0]  vVal;

    assign colLast    = (colCnt == CW'(IMG_W - 1));
    assign rowLast    = (rowCnt == RW'(IMG_H - 1));
    assign colOdd     = colCnt[0];
    assign rowOdd     = rowCnt[0];
    assign frameStart = (colCnt == '0) && (rowCnt == '0);
    // A trailing row of an odd-height frame never pairs, so it must not disturb the buffer.
    assign rowWrOk    = !(HOdd && rowLast);
    assign lbAddr     = OCW'(colCnt >> 1);
    assign lbWe       = iEN && !iCLR && colOdd && !rowOdd && rowWrOk;

    always_comb begin
        hVal = '0;
        vSum = '0;
        vVal = '0;
        if (modeQ == MODE_MAX) begin
            hVal = (DW+1)'(pool_max(POOL_MAX_W'(holdQ), POOL_MAX_W'(iDATA)));
            vVal = DW'(pool_max(POOL_MAX_W'(lbRd), POOL_MAX_W'(hVal)));
        end else begin
            hVal = {1'b0, holdQ} + {1'b0, iDATA};
            vSum = {1'b0, lbRd} + {1'b0, hVal};
            vVal = vSum[DW+1:2];
        end
    end

    pool_line_buf #(
        .DEPTH(OW),
        .WIDTH(DW + 1)
    ) uLineBuf (
        .iCLK  (iCLK),
        .iWE   (lbWe),
        .iWADDR(lbAddr),
        .iWDATA(hVal),
        .iRADDR(lbAddr),
        .oRDATA(lbRd)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            colCnt <= '0;
            rowCnt <= '0;
            holdQ  <= '0;
            modeQ  <= MODE_MAX;
            oDATA  <= '0;
            oVALID <= 1'b0;
            oCOL   <= '0;
            oROW   <= '0;
            oLAST  <= 1'b0;
        end else if (iCLR) begin
            colCnt <= '0;
            rowCnt <= '0;
            holdQ  <= '0;
            oDATA  <= '0;
            oVALID <= 1'b0;
            oCOL   <= '0;
            oROW   <= '0;
            oLAST  <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            oLAST  <= 1'b0;
            if (iEN) begin
                if (frameStart) begin
                    modeQ <= poolMode_e'(iMODE);
                end
                if (!colOdd) begin
                    holdQ <= iDATA;
                end
                if (colLast) begin
                    colCnt <= '0;
                    rowCnt <= rowLast ? '0 : rowCnt + 1'b1;
                end else begin
                    colCnt <= colCnt + 1'b1;
                end
                if (colOdd && rowOdd) begin
                    oVALID <= 1'b1;
                    oDATA  <= vVal;
                    oCOL   <= lbAddr;
                    oROW   <= ORW'(rowCnt >> 1);
                    oLAST  <= (colCnt == CW'(2 * OW - 1)) && (rowCnt == RW'(2 * OH - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream: 4x4 and 5x5 instances against a frame-level model.
module tb_max_pool_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       en4, clr4, mode4, o4Valid, o4Col, o4Row, o4Last;
    logic [7:0] data4, o4Data;
    logic       en5, clr5, mode5, o5Valid, o5Col, o5Row, o5Last;
    logic [7:0] data5, o5Data;

    max_pool_stream #(.DW(8), .IMG_W(4), .IMG_H(4)) u4 (
        .iCLK(clk), .iRSTn(rstn), .iCLR(clr4), .iEN(en4), .iMODE(mode4), .iDATA(data4),
        .oDATA(o4Data), .oVALID(o4Valid), .oCOL(o4Col), .oROW(o4Row), .oLAST(o4Last)
    );

    max_pool_stream #(.DW(8), .IMG_W(5), .IMG_H(5)) u5 (
        .iCLK(clk), .iRSTn(rstn), .iCLR(clr5), .iEN(en5), .iMODE(mode5), .iDATA(data5),
        .oDATA(o5Data), .oVALID(o5Valid), .oCOL(o5Col), .oROW(o5Row), .oLAST(o5Last)
    );

    typedef struct {
        int data;
        int expV;
        int expMax;
        int expAvg;
        int expC;
        int expR;
        int expL;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   mW[2] = '{4, 5};
    int   mH[2] = '{4, 5};
    int   mPos[2];
    int   mMode[2];
    int   mPix[2][25];
    int   got5[$];
    int   px4[16] = '{1, 9, 2, 3, 4, 5, 8, 0, 7, 7, 0, 0, 6, 255, 1, 2};
    vec_t tbl[16];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Pooled value of the 2x2 window whose bottom-right pixel is (c, r) in the current frame.
    function automatic int refVal(input int d, input int c, input int r);
        int w, a, b, e, f, m;
        w = mW[d];
        a = mPix[d][(r-1)*w + c - 1];
        b = mPix[d][(r-1)*w + c];
        e = mPix[d][r*w + c - 1];
        f = mPix[d][r*w + c];
        if (mMode[d] == 0) begin
            m = a;
            if (b > m) m = b;
            if (e > m) m = e;
            if (f > m) m = f;
            return m;
        end
        return (a + b + e + f) / 4;
    endfunction

    task automatic step(input int d, input bit en, input bit clr, input bit mode, input int data);
        int  c, r, w, h, ed, el, gv, gd, gc, gr, gl;
        bit  ev;
        if (d == 0) begin
            en4 = en; clr4 = clr; mode4 = mode; data4 = 8'(data);
        end else begin
            en5 = en; clr5 = clr; mode5 = mode; data5 = 8'(data);
        end
        @(posedge clk);
        @(negedge clk);
        en4 = 1'b0; clr4 = 1'b0; en5 = 1'b0; clr5 = 1'b0;
        w = mW[d]; h = mH[d];
        c = mPos[d] % w; r = mPos[d] / w;
        ev = 1'b0; ed = 0; el = 0;
        if (clr) begin
            mPos[d] = 0;
        end else if (en) begin
            if (mPos[d] == 0) mMode[d] = int'(mode);
            mPix[d][mPos[d]] = data;
            ev = (c % 2 == 1) && (r % 2 == 1);
            if (ev) begin
                ed = refVal(d, c, r);
                el = int'((c == 2*(w/2) - 1) && (r == 2*(h/2) - 1));
            end
            mPos[d] = (mPos[d] + 1) % (w * h);
        end
        gv = (d == 0) ? int'(o4Valid) : int'(o5Valid);
        gd = (d == 0) ? int'(o4Data)  : int'(o5Data);
        gc = (d == 0) ? int'(o4Col)   : int'(o5Col);
        gr = (d == 0) ? int'(o4Row)   : int'(o5Row);
        gl = (d == 0) ? int'(o4Last)  : int'(o5Last);
        chk($sformatf("d%0d valid", d), gv, int'(ev));
        chk($sformatf("d%0d last", d), gl, el);
        if (ev) begin
            chk($sformatf("d%0d data @(%0d,%0d)", d, c/2, r/2), gd, ed);
            chk($sformatf("d%0d col", d), gc, c / 2);
            chk($sformatf("d%0d row", d), gr, r / 2);
        end
        if (d == 1 && gv == 1) got5.push_back(gd);
    endtask

    task automatic tableFrame(input bit mode);
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, 1'b0, mode, tbl[i].data);
            chk("tbl valid", int'(o4Valid), tbl[i].expV);
            if (tbl[i].expV == 1) begin
                chk("tbl data", int'(o4Data), mode ? tbl[i].expAvg : tbl[i].expMax);
                chk("tbl col", int'(o4Col), tbl[i].expC);
                chk("tbl row", int'(o4Row), tbl[i].expR);
                chk("tbl last", int'(o4Last), tbl[i].expL);
            end
        end
    endtask

    initial begin
        int exp5[4] = '{6, 8, 16, 18};
        bit fm;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{data: px4[i], expV: 0, expMax: 0, expAvg: 0, expC: 0, expR: 0, expL: 0};
        end
        tbl[5]  = '{data: px4[5],  expV: 1, expMax: 9,   expAvg: 4,  expC: 0, expR: 0, expL: 0};
        tbl[7]  = '{data: px4[7],  expV: 1, expMax: 8,   expAvg: 3,  expC: 1, expR: 0, expL: 0};
        tbl[13] = '{data: px4[13], expV: 1, expMax: 255, expAvg: 68, expC: 0, expR: 1, expL: 0};
        tbl[15] = '{data: px4[15], expV: 1, expMax: 2,   expAvg: 0,  expC: 1, expR: 1, expL: 1};

        mPos = '{0, 0};
        mMode = '{0, 0};
        en4 = 0; clr4 = 0; mode4 = 0; data4 = 0;
        en5 = 0; clr5 = 0; mode5 = 0; data5 = 0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst valid4", int'(o4Valid), 0);
        chk("rst data4", int'(o4Data), 0);
        chk("rst col4", int'(o4Col), 0);
        chk("rst row4", int'(o4Row), 0);
        chk("rst last4", int'(o4Last), 0);
        chk("rst valid5", int'(o5Valid), 0);
        chk("rst data5", int'(o5Data), 0);
        rstn = 1'b1;
        step(0, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back MAX then AVG frames, no gap cycle between them.
        tableFrame(1'b0);
        tableFrame(1'b1);
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b1, 255);

        // Table data with random idle gaps.
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(0, 1) == 1) step(0, 1'b0, 1'b0, 1'($urandom), $urandom_range(0, 255));
            step(0, 1'b1, 1'b0, 1'b0, px4[i]);
        end

        // Random frames with gaps; iMODE wanders mid-frame and must be ignored.
        for (int f = 0; f < 6; f++) begin
            fm = 1'($urandom);
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(0, 1) == 1) step(0, 1'b0, 1'b0, 1'($urandom), $urandom_range(0, 255));
                step(0, 1'b1, 1'b0, (i == 0) ? fm : 1'($urandom), $urandom_range(0, 255));
            end
        end

        // Clear with a pixel at (2,1), then a full frame.
        for (int i = 0; i < 6; i++) step(0, 1'b1, 1'b0, 1'b1, $urandom_range(0, 255));
        step(0, 1'b1, 1'b1, 1'b1, $urandom_range(0, 255));
        step(0, 1'b0, 1'b0, 1'b0, 0);
        tableFrame(1'b0);

        // Clear coinciding with an output-producing pixel at (1,1); stale buffer then rewritten.
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0, 200 + i);
        step(0, 1'b1, 1'b1, 1'b0, 250);
        step(0, 1'b0, 1'b0, 1'b0, 0);
        step(0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b1, $urandom_range(0, 100));

        // Mode toggled mid-frame 1; frame 2 picks up the new mode.
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, (i >= 8), px4[i]);
        tableFrame(1'b1);

        // 5x5 odd-size frames: trailing column and row produce nothing.
        got5.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) step(1, 1'b1, 1'b0, 1'b0, r*5 + c);
        chk("5x5 count", got5.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got5.size()) chk($sformatf("5x5 out%0d", i), got5[i], exp5[i]);
        end
        for (int f = 0; f < 4; f++) begin
            fm = 1'($urandom);
            for (int i = 0; i < 25; i++) begin
                while ($urandom_range(0, 2) == 0) step(1, 1'b0, 1'b0, 1'($urandom), $urandom_range(0, 255));
                step(1, 1'b1, 1'b0, (i == 0) ? fm : 1'($urandom), $urandom_range(0, 255));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
